// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the iterative shift-add multiplier datapath.
//   state_t        : controller states LOAD / STEP / DONE
//   DEFAULT_WIDTH  : default operand width in bits
//   STEP_W         : width of the iteration counter (holds 0..WIDTH)
// ---------------------------------------------------------------------------
package mul_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int STEP_W        = 6;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mul_pkg

// File: rtl/mul_addsub.sv
// ---------------------------------------------------------------------------
// mul_addsub
// Combinational W-bit adder/subtractor used by the multiplier iteration.
//   a, b   : input  [W-1:0]  operands
//   sub    : input           0 -> a + b, 1 -> a - b
//   result : output [W-1:0]  sum/difference, modulo 2**W
// ---------------------------------------------------------------------------
module mul_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] result
);

    // Two's-complement subtract: invert b and inject the carry-in.
    logic [W-1:0] b_eff;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_inv
            assign b_eff[gi] = b[gi] ^ sub;
        end
    endgenerate

    assign result = a + b_eff + W'(sub);

endmodule : mul_addsub

// File: rtl/mul_datapath.sv
// ---------------------------------------------------------------------------
// mul_datapath
// Iterative multiplier: one shift-add iteration per clk edge while Run is
// high, WIDTH iterations in total. Reset (synchronous, active-high) loads
// the operands and restarts the sequence from any state.
//
// Ports:
//   clk            : input              rising-edge clock
//   Reset          : input              synchronous reset / operand load
//   Run            : input              step enable (low = stall)
//   Multiplicand   : input  [WIDTH-1:0] operand A, sampled on Reset
//   Multiplier     : input  [WIDTH-1:0] operand B, sampled on Reset
//   Product        : output [2W-1:0]    product register
//   Step           : output [5:0]       iterations completed, 0..WIDTH
//   Product_valid  : output             high while Product is final
//
// Build option: define MUL_DATAPATH_SIGNED_EN for a radix-2 Booth
// (two's-complement signed) multiplier; default is unsigned shift-add.
// ---------------------------------------------------------------------------
module mul_datapath
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 Run,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic [2*WIDTH-1:0]   Product,
    output logic [STEP_W-1:0]    Step,
    output logic                 Product_valid
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

    state_t                 state_reg;
    logic [WIDTH-1:0]       mcand_reg;
    logic [2*WIDTH-1:0]     product_reg;
    logic [STEP_W-1:0]      step_reg;
    logic                   valid_reg;

    logic [WIDTH:0]         add_a;
    logic [WIDTH:0]         add_b;
    logic                   add_sub;
    logic [WIDTH:0]         sum;
    logic [2*WIDTH-1:0]     product_next;
    logic                   advance;

    // An iteration happens on any Run-high edge before the sequence ends;
    // DONE ignores Run so the result stays put until the next Reset.
    assign advance = Run && (state_reg != DONE);

`ifdef MUL_DATAPATH_SIGNED_EN
    logic q_m1_reg;

    // Booth pair {LSB, previous LSB}: 01 adds, 10 subtracts, else no-op.
    // Both adder operands are sign-extended so the (WIDTH+1)-bit sum
    // carries the true sign into the arithmetic shift.
    always_comb begin
        add_a   = {product_reg[2*WIDTH-1], product_reg[2*WIDTH-1:WIDTH]};
        add_b   = '0;
        add_sub = 1'b0;
        case ({product_reg[0], q_m1_reg})
            2'b01: add_b = {mcand_reg[WIDTH-1], mcand_reg};
            2'b10: begin
                add_b   = {mcand_reg[WIDTH-1], mcand_reg};
                add_sub = 1'b1;
            end
            default: add_b = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            q_m1_reg <= 1'b0;
        end else if (advance) begin
            q_m1_reg <= product_reg[0];
        end
    end
`else
    // Unsigned: zero-extended upper half plus conditional multiplicand;
    // the extra top bit keeps the carry for the right shift.
    always_comb begin
        add_a   = {1'b0, product_reg[2*WIDTH-1:WIDTH]};
        add_b   = product_reg[0] ? {1'b0, mcand_reg} : '0;
        add_sub = 1'b0;
    end
`endif

    mul_addsub #(
        .W      (WIDTH + 1)
    ) u_addsub (
        .a      (add_a),
        .b      (add_b),
        .sub    (add_sub),
        .result (sum)
    );

    // Shift right by one: the (WIDTH+1)-bit sum becomes the new top half
    // plus bit, so its MSB supplies the logical (carry) or arithmetic
    // (sign) fill depending on the build.
    assign product_next = {sum, product_reg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (Reset) begin
            mcand_reg   <= Multiplicand;
            product_reg <= {{WIDTH{1'b0}}, Multiplier};
            step_reg    <= '0;
            valid_reg   <= 1'b0;
            state_reg   <= LOAD;
        end else if (advance) begin
            product_reg <= product_next;
            step_reg    <= step_reg + STEP_W'(1);
            if (step_reg == LAST_STEP) begin
                state_reg <= DONE;
                valid_reg <= 1'b1;
            end else begin
                state_reg <= STEP;
            end
        end
    end

    assign Product       = product_reg;
    assign Step          = step_reg;
    assign Product_valid = valid_reg;

endmodule : mul_datapath

// File: tb/tb_mul_datapath.sv
// ---------------------------------------------------------------------------
// tb_mul_datapath
// Self-checking bench for mul_datapath (WIDTH = 32). Expected products come
// from plain 64-bit multiplication of the operands; iteration counts come
// from counting Run-high edges after Reset.
// ---------------------------------------------------------------------------
module tb_mul_datapath;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            Reset;
    logic            Run;
    logic [W-1:0]    Multiplicand;
    logic [W-1:0]    Multiplier;
    logic [2*W-1:0]  Product;
    logic [5:0]      Step;
    logic            Product_valid;

    int tests_run    = 0;
    int tests_failed = 0;

    mul_datapath #(
        .WIDTH         (W)
    ) dut (
        .clk           (clk),
        .Reset         (Reset),
        .Run           (Run),
        .Multiplicand  (Multiplicand),
        .Multiplier    (Multiplier),
        .Product       (Product),
        .Step          (Step),
        .Product_valid (Product_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%h", tag, got);
        end
    endtask

    // Reference product from the operands alone.
    function automatic logic [63:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_DATAPATH_SIGNED_EN
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
`else
        logic [63:0] ua;
        logic [63:0] ub;
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset edge loading operands; optionally with Run high to exercise
    // Reset priority. Checks the reset state afterwards.
    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic run_too, input string tag);
        Multiplicand = a;
        Multiplier   = b;
        Reset        = 1'b1;
        Run          = run_too;
        tick();
        Reset = 1'b0;
        Run   = 1'b0;
        check({tag, "_rst_step"},  64'(Step), 64'd0);
        check({tag, "_rst_valid"}, 64'(Product_valid), 64'd0);
        check({tag, "_rst_prod"},  Product, {32'd0, b});
    endtask

    task automatic run_edges(input int n);
        Run = 1'b1;
        repeat (n) tick();
        Run = 1'b0;
    endtask

    logic [63:0] saved;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           runs;
    int           budget;
    logic         bad;

    initial begin
        Reset = 1'b0;
        Run = 1'b0;
        Multiplicand = '0;
        Multiplier = '0;
        tick();

        // 3 x 5: valid must stay low until exactly edge 32
        load(32'd3, 32'd5, 1'b0, "t3x5");
        run_edges(31);
        check("t3x5_step31",  64'(Step), 64'd31);
        check("t3x5_valid31", 64'(Product_valid), 64'd0);
        run_edges(1);
        check("t3x5_valid32", 64'(Product_valid), 64'd1);
        check("t3x5_step32",  64'(Step), 64'd32);
        check("t3x5_prod",    Product, ref_product(32'd3, 32'd5));

        // All ones: carry retention
        load(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "ones");
        run_edges(32);
        check("ones_prod", Product, ref_product(32'hFFFF_FFFF, 32'hFFFF_FFFF));
`ifndef MUL_DATAPATH_SIGNED_EN
        check("ones_const", Product, 64'hFFFF_FFFE_0000_0001);
`endif

        // Stall for 10 cycles after step 12
        load(32'd1000, 32'd999, 1'b0, "stall");
        run_edges(12);
        check("stall_step12", 64'(Step), 64'd12);
        saved = Product;
        repeat (10) tick();
        check("stall_hold_step", 64'(Step), 64'd12);
        check("stall_hold_prod", Product, saved);
        run_edges(20);
        check("stall_prod", Product, 64'd999000);
        check("stall_valid", 64'(Product_valid), 64'd1);

        // Abort at step 16 with new operands
        load(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, "abort_a");
        run_edges(16);
        load(32'd7, 32'd6, 1'b1, "abort_b");
        run_edges(32);
        check("abort_prod", Product, 64'd42);
        check("abort_step", 64'(Step), 64'd32);

        // Operand churn during STEP, then Run held high in DONE
        ra = 32'd51234;
        rb = 32'd7777;
        load(ra, rb, 1'b0, "churn");
        Run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            Multiplicand = $urandom;
            Multiplier   = $urandom;
            tick();
        end
        check("churn_prod", Product, ref_product(ra, rb));
        for (int i = 0; i < 5; i++) begin
            Multiplicand = $urandom;
            Multiplier   = $urandom;
            tick();
        end
        Run = 1'b0;
        check("done_hold_prod",  Product, ref_product(ra, rb));
        check("done_hold_step",  64'(Step), 64'd32);
        check("done_hold_valid", 64'(Product_valid), 64'd1);

`ifdef MUL_DATAPATH_SIGNED_EN
        load(32'hFFFF_FFFD, 32'd5, 1'b0, "sgn_m3x5");
        run_edges(32);
        check("sgn_m3x5_prod", Product, 64'hFFFF_FFFF_FFFF_FFF1);
        load(32'h8000_0000, 32'h8000_0000, 1'b0, "sgn_min");
        run_edges(32);
        check("sgn_min_prod", Product, 64'h4000_0000_0000_0000);
`endif

        // Random operands with random Run stalls
        for (int t = 0; t < 20; t++) begin
            ra = (t == 0) ? 32'd0 : $urandom;
            rb = (t == 1) ? 32'd0 : $urandom;
            load(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
            runs   = 0;
            budget = 0;
            bad    = 1'b0;
            while (runs < W && budget < 400) begin
                Run = ($urandom_range(0, 3) != 0);
                if (Run) runs++;
                Multiplicand = $urandom;
                Multiplier   = $urandom;
                tick();
                budget++;
                if (Step != 6'(runs) || Product_valid != (runs == W)) bad = 1'b1;
            end
            Run = 1'b0;
            check($sformatf("rnd%0d_runs", t),  64'(runs), 64'(W));
            check($sformatf("rnd%0d_track", t), 64'(bad), 64'd0);
            check($sformatf("rnd%0d_prod", t),  Product, ref_product(ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_mul_datapath
